ipv4_hdr_check: RTL and testbench

IPV4_HDR_CHECK -- requirements
Module: ipv4_hdr_check

---
 rtl/ipv4_hdr_check.sv | 135 +++++++++++++
 tb/tb_ipv4_hdr_check.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ipv4_hdr_check.sv
// ipv4_hdr_check: streaming IPv4 header checker.
// Accepts 16-bit header words (word 0 marked by in_sop). It checks version and
// IHL, folds every header word into a ones-complement sum, and captures the
// main fields. It pulses done for one cycle after the last word is accepted.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   in_valid, in_sop    word valid / word is header word 0
//   in_data[15:0]       header word, network order
//   in_ready            block can accept a word this cycle
//   done                one-cycle completion pulse
//   hdr_ok, cksum_ok    version/IHL check, checksum check
//   ihl, total_len, protocol, src_addr, dst_addr   captured fields
module ipv4_hdr_check #(
    parameter int unsigned MIN_IHL = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic        in_sop,
    input  logic [15:0] in_data,
    output logic        in_ready,
    output logic        done,
    output logic        hdr_ok,
    output logic        cksum_ok,
    output logic [3:0]  ihl,
    output logic [15:0] total_len,
    output logic [7:0]  protocol,
    output logic [31:0] src_addr,
    output logic [31:0] dst_addr
);

    // Word count reaches at most 2*15 = 30.
    localparam int unsigned CNT_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] count;
    logic [15:0]      acc;

    logic             accept_c;
    logic [16:0]      sum17_c;
    logic [15:0]      acc_next_c;
    logic [CNT_W-1:0] last_idx_c;
    logic             first_bad_c;

    // in_ready is a direct decode of the state register.
    assign in_ready    = (state != DONE);
    assign accept_c    = in_valid && in_ready;

    // Ones-complement add with end-around carry; the result cannot carry again.
    assign sum17_c     = {1'b0, acc} + {1'b0, in_data};
    assign acc_next_c  = sum17_c[15:0] + {15'd0, sum17_c[16]};

    // Index of the final header word: 2*ihl - 1.
    assign last_idx_c  = {ihl, 1'b0} - CNT_W'(1);

    assign first_bad_c = (in_data[15:12] != 4'd4) ||
                         (32'(in_data[11:8]) < MIN_IHL);

    // Header FSM with accumulator, field capture and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            count     <= '0;
            acc       <= '0;
            done      <= 1'b0;
            hdr_ok    <= 1'b0;
            cksum_ok  <= 1'b0;
            ihl       <= '0;
            total_len <= '0;
            protocol  <= '0;
            src_addr  <= '0;
            dst_addr  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, HDR: begin
                    if (accept_c) begin
                        if (in_sop) begin
                            // Start of a header; also abandons any header in progress.
                            ihl       <= in_data[11:8];
                            acc       <= in_data;
                            count     <= CNT_W'(1);
                            hdr_ok    <= 1'b0;
                            cksum_ok  <= 1'b0;
                            total_len <= '0;
                            protocol  <= '0;
                            src_addr  <= '0;
                            dst_addr  <= '0;
                            if (first_bad_c) begin
                                state <= DONE;
                                done  <= 1'b1;
                            end else begin
                                state <= HDR;
                            end
                        end else if (state == HDR) begin
                            count <= count + CNT_W'(1);
                            acc   <= acc_next_c;
                            // Option words (index >= 10) only feed the checksum.
                            case (count)
                                CNT_W'(1): total_len       <= in_data;
                                CNT_W'(4): protocol        <= in_data[7:0];
                                CNT_W'(6): src_addr[31:16] <= in_data;
                                CNT_W'(7): src_addr[15:0]  <= in_data;
                                CNT_W'(8): dst_addr[31:16] <= in_data;
                                CNT_W'(9): dst_addr[15:0]  <= in_data;
                                default: ;
                            endcase
                            if (count == last_idx_c) begin
                                state    <= DONE;
                                done     <= 1'b1;
                                hdr_ok   <= 1'b1;
                                cksum_ok <= (acc_next_c == 16'hFFFF);
                            end
                        end
                        // Non-sop words in IDLE are dropped.
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ipv4_hdr_check.sv
// tb_ipv4_hdr_check: directed, table-driven bench for ipv4_hdr_check.
module tb_ipv4_hdr_check;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_sop;
    logic [15:0] in_data;
    logic        in_ready;
    logic        done;
    logic        hdr_ok;
    logic        cksum_ok;
    logic [3:0]  ihl;
    logic [15:0] total_len;
    logic [7:0]  protocol;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;

    ipv4_hdr_check #(.MIN_IHL(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_sop    (in_sop),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .done      (done),
        .hdr_ok    (hdr_ok),
        .cksum_ok  (cksum_ok),
        .ihl       (ihl),
        .total_len (total_len),
        .protocol  (protocol),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        string              name;
        int                 n;
        logic [11:0]        gaps;
        logic [0:11][15:0]  w;
        logic               exp_hdr_ok;
        logic               exp_cksum_ok;
        logic [3:0]         exp_ihl;
        logic [15:0]        exp_len;
        logic [7:0]         exp_proto;
        logic [31:0]        exp_src;
        logic [31:0]        exp_dst;
    } vec_t;

    localparam logic [0:11][15:0] H_GOOD = {16'h4500, 16'h0073, 16'h0000, 16'h4000,
        16'h4011, 16'hB861, 16'hC0A8, 16'h0001, 16'hC0A8, 16'h00C7, 16'h0000, 16'h0000};
    localparam logic [0:11][15:0] H_BADCK = {16'h4500, 16'h0073, 16'h0000, 16'h4000,
        16'h4011, 16'hB862, 16'hC0A8, 16'h0001, 16'hC0A8, 16'h00C7, 16'h0000, 16'h0000};
    // IHL=6: word 0 grows by 0x0100, so the checksum word drops by 0x0100.
    localparam logic [0:11][15:0] H_IHL6 = {16'h4600, 16'h0073, 16'h0000, 16'h4000,
        16'h4011, 16'hB761, 16'hC0A8, 16'h0001, 16'hC0A8, 16'h00C7, 16'h0000, 16'h0000};
    localparam logic [0:11][15:0] H_VER6 = {16'h6500, {11{16'h0000}}};
    localparam logic [0:11][15:0] H_IHL4 = {16'h4400, {11{16'h0000}}};

    vec_t vecs [5];
    int   n_cmp    = 0;
    int   n_err    = 0;
    int   done_cnt = 0;

    always @(negedge clk) if (done) done_cnt++;

    function automatic vec_t mk(input string nm, input int n, input logic [11:0] g,
                                input logic [0:11][15:0] w, input logic hok,
                                input logic ck, input logic [3:0] ih,
                                input logic [15:0] len, input logic [7:0] pr,
                                input logic [31:0] s, input logic [31:0] d);
        vec_t v;
        v.name = nm; v.n = n; v.gaps = g; v.w = w;
        v.exp_hdr_ok = hok; v.exp_cksum_ok = ck; v.exp_ihl = ih;
        v.exp_len = len; v.exp_proto = pr; v.exp_src = s; v.exp_dst = d;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_word(input logic sop, input logic [15:0] d);
        int k = 0;
        while (!in_ready && k < 8) begin
            cyc();
            k++;
        end
        chk("in_ready_before_word", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_sop   = sop;
        in_data  = d;
        cyc();
        in_valid = 1'b0;
        in_sop   = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_done"},      32'(done),      32'd0);
        chk({tag, "_hdr_ok"},    32'(hdr_ok),    32'd0);
        chk({tag, "_cksum_ok"},  32'(cksum_ok),  32'd0);
        chk({tag, "_ihl"},       32'(ihl),       32'd0);
        chk({tag, "_total_len"}, 32'(total_len), 32'd0);
        chk({tag, "_protocol"},  32'(protocol),  32'd0);
        chk({tag, "_src_addr"},  src_addr,       32'd0);
        chk({tag, "_dst_addr"},  dst_addr,       32'd0);
    endtask

    task automatic chk_results(input vec_t v, input string tag);
        chk({tag, "_hdr_ok"},    32'(hdr_ok),    32'(v.exp_hdr_ok));
        chk({tag, "_cksum_ok"},  32'(cksum_ok),  32'(v.exp_cksum_ok));
        chk({tag, "_ihl"},       32'(ihl),       32'(v.exp_ihl));
        chk({tag, "_total_len"}, 32'(total_len), 32'(v.exp_len));
        chk({tag, "_protocol"},  32'(protocol),  32'(v.exp_proto));
        chk({tag, "_src_addr"},  src_addr,       v.exp_src);
        chk({tag, "_dst_addr"},  dst_addr,       v.exp_dst);
    endtask

    // Send one header; done must be high right after the last word's edge.
    task automatic run_vec(input vec_t v);
        int base = done_cnt;
        for (int i = 0; i < v.n; i++) begin
            if (v.gaps[i]) repeat (int'($urandom_range(1, 3))) cyc();
            drive_word(i == 0, v.w[i]);
        end
        chk({v.name, "_done_pulse"}, 32'(done), 32'd1);
        chk({v.name, "_in_ready_in_done"}, 32'(in_ready), 32'd0);
        chk_results(v, v.name);
        cyc();
        chk({v.name, "_done_once"}, 32'(done_cnt - base), 32'd1);
        chk({v.name, "_done_low"}, 32'(done), 32'd0);
        chk({v.name, "_ready_after"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        vecs[0] = mk("good",     10, 12'h000,        H_GOOD,  1'b1, 1'b1, 4'd5,
                     16'h0073, 8'h11, 32'hC0A80001, 32'hC0A800C7);
        vecs[1] = mk("ver6",      1, 12'h000,        H_VER6,  1'b0, 1'b0, 4'd5,
                     16'h0000, 8'h00, 32'h0,        32'h0);
        vecs[2] = mk("badck_gap",10, 12'b0110_1001_0110, H_BADCK, 1'b1, 1'b0, 4'd5,
                     16'h0073, 8'h11, 32'hC0A80001, 32'hC0A800C7);
        vecs[3] = mk("ihl4",      1, 12'h000,        H_IHL4,  1'b0, 1'b0, 4'd4,
                     16'h0000, 8'h00, 32'h0,        32'h0);
        vecs[4] = mk("ihl6",     12, 12'h000,        H_IHL6,  1'b1, 1'b1, 4'd6,
                     16'h0073, 8'h11, 32'hC0A80001, 32'hC0A800C7);

        reset    = 1'b1;
        in_valid = 1'b0;
        in_sop   = 1'b0;
        in_data  = '0;
        repeat (2) cyc();
        chk_zero("reset");
        reset = 1'b0;
        chk("ready_after_reset", 32'(in_ready), 32'd1);
        cyc();
        chk("ready_after_reset_1", 32'(in_ready), 32'd1);

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Results hold while idle.
        repeat (3) cyc();
        chk_results(vecs[4], "hold");
        chk("hold_done", 32'(done), 32'd0);

        // Non-sop words in IDLE are dropped.
        base = done_cnt;
        for (int i = 0; i < 10; i++) drive_word(1'b0, H_BADCK[i]);
        cyc();
        chk("drop_no_done", 32'(done_cnt - base), 32'd0);
        chk_results(vecs[4], "drop");

        // New sop after 4 words abandons the partial header.
        base = done_cnt;
        for (int i = 0; i < 4; i++) drive_word(i == 0, H_BADCK[i]);
        run_vec(vecs[0]);
        chk("abandon_single_done", 32'(done_cnt - base), 32'd1);

        // Reset after 5 words discards the partial header.
        base = done_cnt;
        for (int i = 0; i < 5; i++) drive_word(i == 0, H_IHL6[i]);
        reset = 1'b1;
        cyc();
        chk_zero("midreset");
        cyc();
        chk_zero("midreset_1");
        reset = 1'b0;
        chk("midreset_ready", 32'(in_ready), 32'd1);
        chk("midreset_no_done", 32'(done_cnt - base), 32'd0);
        run_vec(vecs[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
